// File: rtl/rpn_token_sequencer.sv
// Front-end of the RPN calculator: classifies UART bytes, drives the digit parser and issues evaluator commands.
// Optional per-number digit limit: compile with `define RPN_SEQ_DIGIT_LIMIT_EN (limit set by MAX_DIGITS).
module rpn_token_sequencer #(
    parameter int MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [3:0]  p_digit,
    output logic        p_wen,
    output logic        p_flush,
    input  logic        p_ready,
    input  logic [15:0] p_dout,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_type,
    output logic [15:0] cmd_data,
    output logic        err
);

    typedef enum logic [2:0] {
        S_INIT, S_INIT_FLUSH, S_INIT_WAIT, S_IDLE,
        S_FLUSH, S_WAIT_RDY, S_CMD_PUSH, S_CMD_AFTER
    } state_e;

    typedef enum logic [1:0] {
        CMD_PUSH  = 2'b00,
        CMD_OP    = 2'b01,
        CMD_EVAL  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {CLS_DIGIT, CLS_DELIM, CLS_CMD, CLS_INVALID} cls_e;

    if (MAX_DIGITS < 1) begin : g_bad_max_digits
        $error("MAX_DIGITS must be at least 1");
    end

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic        after_q, after_d;
    cmd_e        after_type_q, after_type_d;
    logic [1:0]  after_op_q, after_op_d;
    logic [15:0] push_data_q, push_data_d;
    logic        p_wen_q, p_wen_d;
    logic [3:0]  p_digit_q, p_digit_d;
    logic        err_q, err_d;

    cls_e        byte_cls;
    cmd_e        byte_cmd;
    logic [1:0]  byte_op;
    logic        accept;
    logic        digit_ok;

    assign accept = rx_valid && rx_ready;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        byte_cls = CLS_INVALID;
        byte_cmd = CMD_EVAL;
        byte_op  = 2'b00;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            byte_cls = CLS_DIGIT;
        end else begin
            case (rx_data)
                8'h20, 8'h0d, 8'h0a: byte_cls = CLS_DELIM;
                8'h2b: begin byte_cls = CLS_CMD; byte_cmd = CMD_OP; byte_op = 2'b00; end
                8'h2d: begin byte_cls = CLS_CMD; byte_cmd = CMD_OP; byte_op = 2'b01; end
                8'h2a: begin byte_cls = CLS_CMD; byte_cmd = CMD_OP; byte_op = 2'b10; end
                8'h3d: begin byte_cls = CLS_CMD; byte_cmd = CMD_EVAL; end
                8'h63: begin byte_cls = CLS_CMD; byte_cmd = CMD_CLEAR; end
                default: ;
            endcase
        end
    end

`ifdef RPN_SEQ_DIGIT_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [CNT_W-1:0] digit_cnt_q, digit_cnt_d;

    assign digit_ok = (digit_cnt_q != CNT_W'(MAX_DIGITS));

    always_comb begin
        digit_cnt_d = digit_cnt_q;
        if (p_flush) begin
            digit_cnt_d = '0;
        end else if (accept && byte_cls == CLS_DIGIT && digit_ok) begin
            digit_cnt_d = digit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_cnt_q <= '0;
        end else begin
            digit_cnt_q <= digit_cnt_d;
        end
    end
`else
    assign digit_ok = 1'b1;
`endif

    // State register
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:       state_d = S_INIT_FLUSH;
            S_INIT_FLUSH: state_d = S_INIT_WAIT;
            S_INIT_WAIT:  if (p_ready) state_d = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    if (byte_cls == CLS_DELIM && pending_q) begin
                        state_d = S_FLUSH;
                    end else if (byte_cls == CLS_CMD) begin
                        state_d = pending_q ? S_FLUSH : S_CMD_AFTER;
                    end
                end
            end
            S_FLUSH:      state_d = S_WAIT_RDY;
            S_WAIT_RDY:   if (p_ready) state_d = S_CMD_PUSH;
            S_CMD_PUSH:   if (cmd_ready) state_d = after_q ? S_CMD_AFTER : S_IDLE;
            S_CMD_AFTER:  if (cmd_ready) state_d = S_IDLE;
            default:      state_d = S_INIT;
        endcase
    end

    // Datapath registers: digit strobe, pending/after flags, latched command payloads
    always_comb begin
        pending_d    = pending_q;
        after_d      = after_q;
        after_type_d = after_type_q;
        after_op_d   = after_op_q;
        push_data_d  = push_data_q;
        p_wen_d      = 1'b0;
        p_digit_d    = p_digit_q;
        err_d        = 1'b0;

        if (accept) begin
            case (byte_cls)
                CLS_DIGIT: begin
                    if (digit_ok) begin
                        p_wen_d   = 1'b1;
                        p_digit_d = rx_data[3:0];
                        pending_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CLS_CMD: begin
                    after_d      = 1'b1;
                    after_type_d = byte_cmd;
                    after_op_d   = byte_op;
                end
                CLS_INVALID: err_d = 1'b1;
                default: ;
            endcase
        end

        if (state_q == S_WAIT_RDY && p_ready) begin
            push_data_d = p_dout;
            pending_d   = 1'b0;
        end

        if (state_q == S_CMD_AFTER && cmd_ready) begin
            after_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= 1'b0;
            after_q      <= 1'b0;
            after_type_q <= CMD_PUSH;
            after_op_q   <= 2'b00;
            push_data_q  <= '0;
            p_wen_q      <= 1'b0;
            p_digit_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            after_q      <= after_d;
            after_type_q <= after_type_d;
            after_op_q   <= after_op_d;
            push_data_q  <= push_data_d;
            p_wen_q      <= p_wen_d;
            p_digit_q    <= p_digit_d;
            err_q        <= err_d;
        end
    end

    // Outputs decoded from state; the reset state S_INIT drives nothing
    always_comb begin
        rx_ready  = (state_q == S_IDLE);
        p_flush   = (state_q == S_INIT_FLUSH) || (state_q == S_FLUSH);
        cmd_valid = 1'b0;
        cmd_type  = CMD_PUSH;
        cmd_data  = '0;
        case (state_q)
            S_CMD_PUSH: begin
                cmd_valid = 1'b1;
                cmd_data  = push_data_q;
            end
            S_CMD_AFTER: begin
                cmd_valid = 1'b1;
                cmd_type  = after_type_q;
                cmd_data  = {14'd0, after_op_q};
            end
            default: ;
        endcase
    end

    assign p_wen   = p_wen_q;
    assign p_digit = p_digit_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rpn_token_sequencer.sv
// Self-checking bench for rpn_token_sequencer: behavioural digit parser, command scoreboard, timing spot checks.
module tb_rpn_token_sequencer;

    localparam int MAX_D = 5;

    typedef struct {
        logic [1:0]  t;
        logic [15:0] d;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  p_digit;
    logic        p_wen;
    logic        p_flush;
    logic        p_ready;
    logic [15:0] p_dout;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [15:0] cmd_data;
    logic        err;

    rpn_token_sequencer #(.MAX_DIGITS(MAX_D)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .p_digit   (p_digit),
        .p_wen     (p_wen),
        .p_flush   (p_flush),
        .p_ready   (p_ready),
        .p_dout    (p_dout),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_data  (cmd_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural decimal parser; the reset value is deliberate garbage the INIT flush must discard.
    logic [15:0] par_acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            par_acc <= 16'd777;
            p_ready <= 1'b0;
            p_dout  <= '0;
        end else begin
            p_ready <= p_flush;
            if (p_flush) begin
                p_dout  <= par_acc;
                par_acc <= '0;
            end else if (p_wen) begin
                par_acc <= par_acc * 16'd10 + {12'd0, p_digit};
            end
        end
    end

    // Reference model state and scoreboards
    cmd_t        exp_q[$];
    logic [3:0]  dig_q[$];
    logic [15:0] m_num = '0;
    bit          m_pending = 0;
    int          m_cnt = 0;
    int          exp_err = 0;
    int          got_err = 0;
    int          exp_flush = 1;
    int          flush_cnt = 0;
    int          cmd_cnt = 0;
    logic        prev_flush = 1'b0;

    task automatic push_num();
        exp_q.push_back('{2'b00, m_num});
        exp_flush++;
        m_num     = '0;
        m_pending = 0;
        m_cnt     = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) begin
`ifdef RPN_SEQ_DIGIT_LIMIT_EN
            if (m_cnt == MAX_D) begin
                exp_err++;
                return;
            end
`endif
            m_cnt++;
            m_num     = m_num * 16'd10 + {8'd0, b - 8'h30};
            m_pending = 1;
            dig_q.push_back(4'(b - 8'h30));
        end else if (b == 8'h20 || b == 8'h0d || b == 8'h0a) begin
            if (m_pending) push_num();
        end else if (b == 8'h2b || b == 8'h2d || b == 8'h2a || b == 8'h3d || b == 8'h63) begin
            if (m_pending) push_num();
            case (b)
                8'h2b:   exp_q.push_back('{2'b01, 16'd0});
                8'h2d:   exp_q.push_back('{2'b01, 16'd1});
                8'h2a:   exp_q.push_back('{2'b01, 16'd2});
                8'h3d:   exp_q.push_back('{2'b10, 16'd0});
                default: exp_q.push_back('{2'b11, 16'd0});
            endcase
        end else begin
            exp_err++;
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (p_wen) begin
                check("wen_flush_excl", p_flush, 1'b0);
                check("wen_expected", 32'(dig_q.size() != 0), 1);
                if (dig_q.size() != 0) check("p_digit", p_digit, dig_q.pop_front());
            end
            if (p_flush) begin
                flush_cnt++;
                check("flush_gap", prev_flush, 1'b0);
            end
            prev_flush = p_flush;
            if (err) got_err++;
            if (cmd_valid && cmd_ready) begin
                cmd_t e;
                cmd_cnt++;
                check("cmd_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("cmd_type", cmd_type, e.t);
                    check("cmd_data", cmd_data, e.d);
                end
            end
        end else begin
            prev_flush = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        model_byte(b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_accept", rx_ready, 1'b1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || dig_q.size() != 0 || !rx_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_cmds_left"}, exp_q.size(), 0);
        check({tag, "_err_count"}, got_err, exp_err);
        check({tag, "_flush_count"}, flush_cnt, exp_flush);
    endtask

    task automatic wait_cmd_valid();
        int n = 0;
        while (!cmd_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_valid_wait", cmd_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = '0;
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {rx_ready, p_wen, p_flush, p_digit, cmd_valid, cmd_type, cmd_data, err}, 0);

        // INIT sequence: flush in cycle 1, parser ready in cycle 2, rx_ready from cycle 3
        rst = 1'b0;
        @(negedge clk);
        check("init_c1_flush", p_flush, 1'b1);
        check("init_c1_rx_ready", rx_ready, 1'b0);
        @(negedge clk);
        check("init_c2_flush", p_flush, 1'b0);
        check("init_c2_rx_ready", rx_ready, 1'b0);
        @(negedge clk);
        check("init_c3_rx_ready", rx_ready, 1'b1);
        repeat (4) @(negedge clk);
        check("init_flush_count", flush_cnt, 1);
        check("init_no_cmd", cmd_cnt, 0);

        // "12 " with delimiter timing
        send_str("12");
        send_byte(8'h20);
        @(negedge clk);
        check("delim_n1_flush", p_flush, 1'b1);
        @(negedge clk);
        check("delim_n2_flush", p_flush, 1'b0);
        @(negedge clk);
        check("delim_n3_valid", cmd_valid, 1'b1);
        check("delim_n3_data", cmd_data, 16'd12);
        @(negedge clk);
        check("delim_n4_rx_ready", rx_ready, 1'b1);
        drain("s12");

        // "7 3-" with operator timing: PUSH at N+3, OP at N+4
        send_str("7 3");
        send_byte(8'h2d);
        repeat (3) @(negedge clk);
        check("op_n3_push", {cmd_valid, cmd_type}, {1'b1, 2'b00});
        @(negedge clk);
        check("op_n4_op", {cmd_valid, cmd_type, cmd_data}, {1'b1, 2'b01, 16'd1});
        drain("s73");

        // "45=" with the evaluator stalling for 5 cycles
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        send_str("45=");
        wait_cmd_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_push_hold", {cmd_valid, cmd_type, cmd_data}, {1'b1, 2'b00, 16'd45});
            check("stall_rx_ready", rx_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 cmd_ready = 1'b1;
        drain("s45");

        // Invalid byte in the middle of a number
        send_str("9x9");
        send_byte(8'h0a);
        drain("s9x9");

        // Six digits: limited to 12345 with the macro, wraps to 57920 without
        send_str("123456 ");
        drain("s123456");

        // Clear with a pending number, then operators with nothing pending
        send_str("8c+*");
        drain("s8c");

        // Reset while a PUSH is stalled
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        send_str("3 ");
        wait_cmd_valid();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midop_reset_outputs",
              {rx_ready, p_wen, p_flush, p_digit, cmd_valid, cmd_type, cmd_data, err}, 0);
        exp_q.delete();
        dig_q.delete();
        m_num     = '0;
        m_pending = 0;
        m_cnt     = 0;
        flush_cnt = 0;
        exp_flush = 1;
        @(negedge clk);
        rst       = 1'b0;
        cmd_ready = 1'b1;
        drain("reinit");
        send_str("21 ");
        drain("s21");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
